base_burst_gather_fifo: RTL and testbench
=========================================

Name: base_burst_gather_fifo

Overview:
- Per-way input buffer placed directly upstream of one input way of the multi-level round-robin arbiter.
- Accepts beats with an end-of-burst marker and stores them.
- Presents the head beat to the arbiter only once a complete burst is stored, so the hold signal never stalls the arbiter mid-burst.
- Drives the arbiter's valid, hold and data for that way: o_h=1 on every beat except the last of a burst.

Parameters:
- width, 8: data bits per beat.
- depth, 16: entry count; must be a power of 2, at least 2.
- awidth, 4: pointer width; must equal log2(depth).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- i_r  out  1  ready to accept a beat.
- i_v  in  1  beat valid.
- i_e  in  1  end of burst; qualifies the beat with i_v.
- i_d  in  width  beat data.
- o_r  in  1  arbiter ready for this way.
- o_v  out  1  head beat valid to arbiter.
- o_h  out  1  hold; 1 = more beats of this burst follow.
- o_d  out  width  head beat data.
- o_cnt  out  awidth+1  number of entries stored, 0..depth.

Behaviour:
- Storage: depth entries of {e, d}; write pointer wp and read pointer rp (awidth bits each, wrapping modulo depth); entry count cnt (awidth+1 bits); complete-burst count bc (awidth+1 bits).
- Reset (reset=0): wp=rp=cnt=bc=0 asynchronously. While reset is low: i_r=0, o_v=0, o_h=0, o_d=0, o_cnt=0. Array contents are not reset.
- i_r = (cnt != depth), decoded from registered state only; no combinational path from o_r. First cycle after reset release: i_r=1.
- Write: on clk when i_v & i_r. Store {i_e, i_d} at wp; wp+1. Beats offered while i_r=0 are not accepted; the sender holds them.
- Read: on clk when o_v & o_r. rp+1.
- cnt: +1 on write only, -1 on read only, unchanged when both occur in the same cycle.
- bc: +1 on write with i_e=1, -1 on read of a head entry with e=1, unchanged when both occur in the same cycle.
- Forced release: fr = (cnt == depth) & (bc == 0). This covers a burst longer than depth; the block cuts through to avoid deadlock.
- o_v = (cnt != 0) & ((bc != 0) | fr_latched).
  - fr_latched sets when fr=1.
  - fr_latched clears when a beat with e=1 is read.
  - While fr_latched=1, o_v tracks cnt != 0; the burst streams without the full-burst guarantee.
- o_h = o_v & ~head.e.
- o_d = head.d when o_v=1, else 0.
- Latency: a burst whose last beat is written in cycle t gives o_v=1 in cycle t+1 at the earliest (registered bc). Read-to-write turnaround at full: a read in cycle t gives i_r=1 in cycle t+1.
- Boundaries:
  - Simultaneous read and write at full: write is blocked (i_r=0) and the read proceeds.
  - Simultaneous read and write at cnt=1: both occur; cnt stays 1.
  - Pointer wrap from depth-1 to 0 is seamless.
  - i_e on a single-beat burst: o_h=0 for that beat.
- Reset mid-burst: all partial data is discarded; no output glitch beyond the asynchronous drop of o_v to 0.
- o_cnt = cnt.

Optional Feature:
- Macro BASE_BURST_GATHER_ERR_EN.
- Defined: adds output port o_err (1 bit). o_err is a sticky flag set in the cycle after fr first becomes 1, and cleared only by reset (o_err=0 during and after reset).
- Not defined: no o_err port. Forced-release behaviour is otherwise identical.

Test Plan:
- Write 3 beats d=0x11,0x22,0x33 (e on the last) with o_r=1 -> o_v=0 until the cycle after 0x33 is written; then o_d=0x11/0x22/0x33 in consecutive cycles with o_h=1,1,0; o_cnt returns to 0.
- Fill 16 single-beat bursts with o_r=0 -> i_r=0 when o_cnt=16. Pulse o_r for one cycle -> head popped; i_r=1 next cycle.
- 20-beat burst, depth 16, o_r=1 -> fr at cnt=16; o_v asserts; beats stream in order with o_h=1 on beats 1-19 and o_h=0 on beat 20; o_err=1 when BASE_BURST_GATHER_ERR_EN is defined.
- Simultaneous write of an e=1 beat and read of an e=1 head beat with bc=1 -> bc stays 1, cnt unchanged, o_v stays 1.
- Assert reset low mid-burst with cnt=5 -> o_v, o_h, o_d, o_cnt all 0 immediately. After release, i_r=1 and the next 1-beat burst emerges alone.
- Write 40 two-beat bursts with random o_r stalls -> output order is preserved across pointer wrap, and o_h never deasserts before an e=1 beat.

Source files
------------

// File: rtl/base_burst_gather_fifo.sv
// Per-way burst-gathering FIFO feeding one input way of the round-robin arbiter.
// Optional sticky forced-release flag o_err is enabled by defining BASE_BURST_GATHER_ERR_EN.
module base_burst_gather_fifo #(
  parameter int width  = 8,
  parameter int depth  = 16,
  parameter int awidth = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              i_r,
  input  logic              i_v,
  input  logic              i_e,
  input  logic [width-1:0]  i_d,
  input  logic              o_r,
  output logic              o_v,
  output logic              o_h,
  output logic [width-1:0]  o_d,
  output logic [awidth:0]   o_cnt
`ifdef BASE_BURST_GATHER_ERR_EN
  ,
  output logic              o_err
`endif
);

  localparam logic [awidth:0]   FULL = (awidth+1)'(depth);
  localparam logic [awidth:0]   CONE = (awidth+1)'(1);
  localparam logic [awidth-1:0] PONE = awidth'(1);

  logic [width:0]      mem_q [depth];
  logic [awidth-1:0]   wp_q, wp_d;
  logic [awidth-1:0]   rp_q, rp_d;
  logic [awidth:0]     cnt_q, cnt_d;
  logic [awidth:0]     bc_q, bc_d;
  logic                frl_q, frl_d;

  logic [width:0]      head;
  logic                head_e;
  logic                full;
  logic                fr;
  logic                wr;
  logic                rd;
  logic                bc_inc;
  logic                bc_dec;

  assign head   = mem_q[rp_q];
  assign head_e = head[width];
  assign full   = (cnt_q == FULL);
  // A full buffer with no complete burst can never drain on its own.
  assign fr     = full & (bc_q == '0);

  // Gated by reset so the sender sees not-ready while reset is held.
  assign i_r    = reset & ~full;
  assign o_v    = (cnt_q != '0) & ((bc_q != '0) | frl_q);
  assign o_h    = o_v & ~head_e;
  assign o_d    = o_v ? head[width-1:0] : '0;
  assign o_cnt  = cnt_q;

  assign wr     = i_v & i_r;
  assign rd     = o_v & o_r;
  assign bc_inc = wr & i_e;
  assign bc_dec = rd & head_e;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    bc_d  = bc_q;
    frl_d = frl_q;
    if (wr) wp_d = wp_q + PONE;
    if (rd) rp_d = rp_q + PONE;
    case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CONE;
      2'b01:   cnt_d = cnt_q - CONE;
      default: cnt_d = cnt_q;
    endcase
    case ({bc_inc, bc_dec})
      2'b10:   bc_d = bc_q + CONE;
      2'b01:   bc_d = bc_q - CONE;
      default: bc_d = bc_q;
    endcase
    if (bc_dec) frl_d = 1'b0;
    if (fr)     frl_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= {i_e, i_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      bc_q  <= '0;
      frl_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      bc_q  <= bc_d;
      frl_q <= frl_d;
    end
  end

`ifdef BASE_BURST_GATHER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | fr;
  end

  assign o_err = err_q;
`endif

endmodule

// File: tb/tb_base_burst_gather_fifo.sv
// Directed self-checking bench for base_burst_gather_fifo (depth 16, width 8).
module tb_base_burst_gather_fifo;

  logic       clk;
  logic       reset;
  logic       i_r;
  logic       i_v;
  logic       i_e;
  logic [7:0] i_d;
  logic       o_r;
  logic       o_v;
  logic       o_h;
  logic [7:0] o_d;
  logic [4:0] o_cnt;
`ifdef BASE_BURST_GATHER_ERR_EN
  logic       o_err;
`endif

  int checks = 0;
  int errors = 0;

  base_burst_gather_fifo #(.width(8), .depth(16), .awidth(4)) dut (
    .clk   (clk),
    .reset (reset),
    .i_r   (i_r),
    .i_v   (i_v),
    .i_e   (i_e),
    .i_d   (i_d),
    .o_r   (o_r),
    .o_v   (o_v),
    .o_h   (o_h),
    .o_d   (o_d),
    .o_cnt (o_cnt)
`ifdef BASE_BURST_GATHER_ERR_EN
    ,
    .o_err (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sender advances on i_v&i_r, receiver on o_v&o_r; beat k carries base+k.
  task automatic stream(input int nb, input int blen, input bit rnd, input int base, input int s0);
    int s;
    int r;
    int n;
    bit w;
    bit rdk;
    s = s0;
    r = 0;
    n = 0;
    while (r < nb && n < 2000) begin
      i_v = (s < nb);
      i_d = 8'(base + s);
      i_e = ((s % blen) == blen - 1);
      o_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_v) begin
        chk("strm_d", o_d, 8'(base + r));
        chk("strm_h", o_h, ((r % blen) == blen - 1) ? 0 : 1);
      end
      w   = i_v & i_r;
      rdk = o_v & o_r;
      cyc();
      if (w)   s++;
      if (rdk) r++;
      n++;
    end
    i_v = 1'b0;
    o_r = 1'b0;
    chk("strm_done", r, nb);
  endtask

  initial begin
    reset = 1'b0;
    i_v   = 1'b0;
    i_e   = 1'b0;
    i_d   = '0;
    o_r   = 1'b0;
    #3;
    chk("rst_ir", i_r, 0);
    chk("rst_ov", o_v, 0);
    chk("rst_oh", o_h, 0);
    chk("rst_od", o_d, 0);
    chk("rst_cnt", o_cnt, 0);
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rel_ir", i_r, 1);

    // Three-beat burst; released only after the last beat lands.
    o_r = 1'b1;
    i_v = 1'b1; i_d = 8'h11; i_e = 1'b0;
    cyc();
    chk("b3_ov0", o_v, 0);
    i_d = 8'h22;
    cyc();
    chk("b3_ov1", o_v, 0);
    chk("b3_cnt", o_cnt, 2);
    i_d = 8'h33; i_e = 1'b1;
    cyc();
    i_v = 1'b0;
    chk("b3_v1", o_v, 1);
    chk("b3_d1", o_d, 8'h11);
    chk("b3_h1", o_h, 1);
    cyc();
    chk("b3_d2", o_d, 8'h22);
    chk("b3_h2", o_h, 1);
    cyc();
    chk("b3_d3", o_d, 8'h33);
    chk("b3_h3", o_h, 0);
    cyc();
    chk("b3_ov_end", o_v, 0);
    chk("b3_cnt_end", o_cnt, 0);

    // Fill with single-beat bursts, then read/write collision at full.
    o_r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      i_v = 1'b1; i_d = 8'(8'h40 + i); i_e = 1'b1;
      cyc();
    end
    i_d = 8'h99;
    chk("full_ir", i_r, 0);
    chk("full_cnt", o_cnt, 16);
    chk("full_ov", o_v, 1);
    chk("full_od", o_d, 8'h40);
    chk("full_oh", o_h, 0);
    o_r = 1'b1;
    cyc();
    o_r = 1'b0;
    chk("pop_cnt", o_cnt, 15);
    chk("pop_ir", i_r, 1);
    chk("pop_od", o_d, 8'h41);
    cyc();
    i_v = 1'b0;
    chk("refill_cnt", o_cnt, 16);
    o_r = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_d", o_d, (i < 15) ? 8'(8'h41 + i) : 8'h99);
      cyc();
    end
    o_r = 1'b0;
    chk("drain_cnt", o_cnt, 0);
    chk("drain_ov", o_v, 0);
`ifdef BASE_BURST_GATHER_ERR_EN
    chk("err_clear", o_err, 0);
`endif

    // Burst longer than depth forces cut-through.
    o_r = 1'b1;
    for (int k = 0; k < 16; k++) begin
      i_v = 1'b1; i_d = 8'(8'h60 + k); i_e = 1'b0;
      cyc();
    end
    i_v = 1'b0;
    chk("fr_cnt", o_cnt, 16);
    chk("fr_ov_pre", o_v, 0);
    chk("fr_ir", i_r, 0);
    stream(20, 20, 1'b0, 8'h60, 16);
    chk("fr_cnt_end", o_cnt, 0);
`ifdef BASE_BURST_GATHER_ERR_EN
    chk("err_set", o_err, 1);
`endif
    i_v = 1'b1; i_d = 8'hEE; i_e = 1'b0;
    cyc();
    chk("frl_clr_ov", o_v, 0);
    i_d = 8'hEF; i_e = 1'b1;
    cyc();
    i_v = 1'b0;
    chk("post_fr_ov", o_v, 1);
    chk("post_fr_d", o_d, 8'hEE);
    chk("post_fr_h", o_h, 1);
    o_r = 1'b1;
    cyc();
    cyc();
    o_r = 1'b0;
    chk("post_fr_cnt", o_cnt, 0);

    // Write and read of e=1 beats in the same cycle with bc=1, cnt=1.
    i_v = 1'b1; i_d = 8'hA1; i_e = 1'b1;
    cyc();
    i_d = 8'hA2;
    o_r = 1'b1;
    cyc();
    i_v = 1'b0;
    chk("sim_cnt", o_cnt, 1);
    chk("sim_ov", o_v, 1);
    chk("sim_od", o_d, 8'hA2);
    chk("sim_oh", o_h, 0);
    cyc();
    o_r = 1'b0;
    chk("sim_drain", o_cnt, 0);

    // Reset mid-burst with five entries stored.
    for (int k = 0; k < 5; k++) begin
      i_v = 1'b1; i_d = 8'(8'hB0 + k); i_e = (k == 1);
      cyc();
    end
    i_v = 1'b0;
    chk("mid_cnt", o_cnt, 5);
    chk("mid_ov", o_v, 1);
    chk("mid_oh", o_h, 1);
    chk("mid_od", o_d, 8'hB0);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_ov", o_v, 0);
    chk("mrst_oh", o_h, 0);
    chk("mrst_od", o_d, 0);
    chk("mrst_cnt", o_cnt, 0);
    chk("mrst_ir", i_r, 0);
`ifdef BASE_BURST_GATHER_ERR_EN
    chk("mrst_err", o_err, 0);
`endif
    cyc();
    reset = 1'b1;
    #1;
    chk("mrel_ir", i_r, 1);
    chk("mrel_ov", o_v, 0);
    i_v = 1'b1; i_d = 8'hC5; i_e = 1'b1;
    cyc();
    i_v = 1'b0;
    chk("one_ov", o_v, 1);
    chk("one_od", o_d, 8'hC5);
    chk("one_oh", o_h, 0);
    chk("one_cnt", o_cnt, 1);
    o_r = 1'b1;
    cyc();
    o_r = 1'b0;
    chk("one_gone", o_v, 0);
    chk("one_cnt0", o_cnt, 0);

    // 40 two-beat bursts with random stalls across pointer wrap.
    stream(80, 2, 1'b1, 0, 0);
    chk("wrap_cnt", o_cnt, 0);
    chk("wrap_ov", o_v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
